// File: rtl/pipe_if_fetch_if.sv
// Instruction-memory fetch bus between the IF stage and instruction memory.
//   imem_req    : fetch request valid (IF -> memory)
//   imem_addr   : fetch address, word aligned (IF -> memory)
//   imem_ready  : memory accepts the request this cycle (memory -> IF)
//   imem_rvalid : read data valid, at least one cycle after acceptance (memory -> IF)
//   imem_rdata  : fetched instruction word (memory -> IF)
// The master modport is the fetch unit; the slave modport is the memory.
interface pipe_if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/pipe_if_fetch.sv
// IF stage: owns the architectural fetch PC, issues single-outstanding fetches
// to instruction memory, and presents fetched instructions at the IF/ID boundary.
// A one-entry skid buffer absorbs a response that arrives while ID is stalled.
// Ports:
//   clk, rstn       : clock (rising edge) and synchronous active-low reset
//   PCOP, NPC       : redirect request from EXE and its target
//   stall           : ID not accepting; IF/ID contents hold
//   imem            : instruction-memory bus (master side)
//   if_valid/if_pc/if_inst : IF/ID register contents
//   if_pcplus4      : if_pc + 4 (combinational, wraps mod 2^32)
module pipe_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  PCOP,
    input  logic [31:0]           NPC,
    input  logic                  stall,
    pipe_if_fetch_if.master       imem,
    output logic                  if_valid,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_inst,
    output logic [31:0]           if_pcplus4
);

    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        kill_q, kill_d;
    logic        req_q, req_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;

    logic        accept_s;
    logic        resp_s;
    logic        out_free_s;

    // imem_req mirrors state REQ, so acceptance only needs the state and ready.
    assign accept_s   = (state_q == S_REQ) && imem.imem_ready;
    assign resp_s     = (state_q == S_WAIT) && imem.imem_rvalid;
    assign out_free_s = !if_valid_q || !stall;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            kill_q      <= 1'b0;
            req_q       <= 1'b0;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
            skid_inst_q <= NOP_INST;
            skid_pc_q   <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_pc_q     <= RESET_PC;
            if_inst_q   <= NOP_INST;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            req_q       <= req_d;
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
        end
    end

    // Next-state logic; kill marks an accepted fetch whose response must be dropped.
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem.imem_ready) begin
                    // A redirect in the accepting cycle still issues the old address.
                    state_d = S_WAIT;
                    kill_d  = PCOP;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    kill_d = 1'b0;
                    if (PCOP || kill_q || out_free_s) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else begin
                    kill_d  = kill_q | PCOP;
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (PCOP || !stall) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    // Output and datapath next values: PC advance, IF/ID loading, skid, flush.
    always_comb begin
        pc_d        = pc_q;
        fetch_pc_d  = fetch_pc_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;
        if (stall) begin
            if_valid_d = if_valid_q;
        end else begin
            if_valid_d = 1'b0;
        end

        if (accept_s) begin
            fetch_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        if (PCOP) begin
            // Redirect overrides the PC advance and flushes IF/ID even under stall.
            pc_d       = NPC & ADDR_MASK;
            if_valid_d = 1'b0;
            if_inst_d  = NOP_INST;
        end else if (resp_s && !kill_q) begin
            if (out_free_s) begin
                if_valid_d = 1'b1;
                if_pc_d    = fetch_pc_q;
                if_inst_d  = imem.imem_rdata;
            end else begin
                skid_inst_d = imem.imem_rdata;
                skid_pc_d   = fetch_pc_q;
            end
        end else if ((state_q == S_HOLD) && !stall) begin
            if_valid_d = 1'b1;
            if_pc_d    = skid_pc_q;
            if_inst_d  = skid_inst_q;
        end else begin
            skid_pc_d = skid_pc_q;
        end

        req_d = (state_d == S_REQ);
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_inst        = if_inst_q;
    assign if_pcplus4     = if_pc_q + 32'd4;

endmodule

// File: tb/tb_pipe_if_fetch.sv
module tb_pipe_if_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rstn;
    logic        pcop;
    logic [31:0] npc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] if_pcplus4;

    pipe_if_fetch_if imem ();

    pipe_if_fetch #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .PCOP       (pcop),
        .NPC        (npc),
        .stall      (stall),
        .imem       (imem.master),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .if_pcplus4 (if_pcplus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: memory contents, outstanding fetch, expected fetch/delivery order.
    logic        outstanding;
    int          wait_cnt;
    int          lat_cfg;
    logic [31:0] mem_addr;
    logic [31:0] next_fetch;
    logic [31:0] exp_pc;
    logic        stale_rvalid;
    logic        model_rvalid;
    int          n_consumed;
    logic        prev_pending;
    logic [31:0] prev_addr;

    logic        s_rstn, s_req, s_ready, s_pcop, s_stall, s_valid;
    logic [31:0] s_addr, s_npc, s_if_pc, s_if_inst;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'h00A0_0093 ^ (a * 32'h0001_0001);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mem_drive();
        if (outstanding && wait_cnt == 0) begin
            model_rvalid     = 1'b1;
            imem.imem_rvalid = 1'b1;
            imem.imem_rdata  = memw(mem_addr);
        end else begin
            model_rvalid     = 1'b0;
            imem.imem_rvalid = stale_rvalid;
            imem.imem_rdata  = stale_rvalid ? 32'hDEAD_BEEF : 32'h0000_0000;
        end
    endtask

    // One clock cycle: drive memory, check at negedge, update model after posedge.
    task automatic tick();
        logic [31:0] tgt;
        mem_drive();
        @(negedge clk);
        s_rstn = rstn; s_req = imem.imem_req; s_ready = imem.imem_ready;
        s_pcop = pcop; s_stall = stall; s_valid = if_valid;
        s_addr = imem.imem_addr; s_npc = npc; s_if_pc = if_pc; s_if_inst = if_inst;
        if (s_rstn) begin
            chk("one_outstanding", 32'(imem.imem_req && outstanding), 32'd0);
            chk("pcplus4", if_pcplus4, if_pc + 32'd4);
            if (if_valid) chk("inst_content", if_inst, memw(if_pc));
            if (prev_pending) begin
                chk("req_hold", 32'(imem.imem_req), 32'd1);
                chk("addr_hold", imem.imem_addr, prev_addr);
            end
        end
        @(posedge clk);
        #1;
        if (!s_rstn) begin
            outstanding  = 1'b0;
            wait_cnt     = 0;
            next_fetch   = RST_PC;
            exp_pc       = RST_PC;
            prev_pending = 1'b0;
            chk("rst_valid", 32'(if_valid), 32'd0);
            chk("rst_pc", if_pc, RST_PC);
            chk("rst_inst", if_inst, NOP);
            chk("rst_req", 32'(imem.imem_req), 32'd0);
        end else begin
            if (model_rvalid) outstanding = 1'b0;
            else if (outstanding && wait_cnt > 0) wait_cnt--;
            if (s_req && s_ready) begin
                chk("fetch_addr", s_addr, next_fetch);
                next_fetch  = next_fetch + 32'd4;
                outstanding = 1'b1;
                mem_addr    = s_addr;
                wait_cnt    = lat_cfg;
            end
            if (s_valid && !s_stall && !s_pcop) begin
                chk("stream_pc", s_if_pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
            if (s_pcop) begin
                tgt        = s_npc & 32'hFFFF_FFFC;
                exp_pc     = tgt;
                next_fetch = tgt;
                chk("flush_valid", 32'(if_valid), 32'd0);
                chk("flush_inst", if_inst, NOP);
            end else if (s_stall && s_valid) begin
                chk("hold_valid", 32'(if_valid), 32'd1);
                chk("hold_pc", if_pc, s_if_pc);
                chk("hold_inst", if_inst, s_if_inst);
            end
            prev_pending = s_req && !s_ready && !s_pcop;
            prev_addr    = s_addr;
        end
    endtask

    initial begin
        rstn = 1'b0; pcop = 1'b0; npc = 32'd0; stall = 1'b0;
        imem.imem_ready = 1'b1; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'd0;
        outstanding = 1'b0; wait_cnt = 0; lat_cfg = 0; mem_addr = 32'd0;
        next_fetch = RST_PC; exp_pc = RST_PC; stale_rvalid = 1'b0; model_rvalid = 1'b0;
        n_consumed = 0; prev_pending = 1'b0; prev_addr = 32'd0;

        // Reset, then first fetch from address 0 with 1-cycle memory.
        #1;
        tick(); tick();
        rstn = 1'b1;
        tick();
        chk("first_req", 32'(imem.imem_req), 32'd1);
        chk("first_addr", imem.imem_addr, 32'h0000_0000);
        tick(); tick();
        chk("first_valid", 32'(if_valid), 32'd1);
        chk("first_pc", if_pc, 32'h0000_0000);
        chk("first_inst", if_inst, 32'h00A0_0093);
        chk("first_pcplus4", if_pcplus4, 32'h0000_0004);
        chk("second_addr", imem.imem_addr, 32'h0000_0004);

        // Stall for three cycles while the response to 4 returns.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", if_pc, 32'h0000_0000);
            if (i > 0) chk("stall_req", 32'(imem.imem_req), 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("unstall_pc", if_pc, 32'h0000_0004);
        chk("unstall_valid", 32'(if_valid), 32'd1);
        chk("unstall_addr", imem.imem_addr, 32'h0000_0008);

        // Redirect while waiting on address 8.
        lat_cfg = 2;
        tick();
        lat_cfg = 0;
        pcop = 1'b1; npc = 32'h0000_0100;
        tick();
        pcop = 1'b0;
        chk("redir_valid", 32'(if_valid), 32'd0);
        for (int i = 0; i < 10 && !imem.imem_req; i++) tick();
        chk("redir_req_seen", 32'(imem.imem_req), 32'd1);
        chk("redir_addr", imem.imem_addr, 32'h0000_0100);
        chk("redir_no_old", 32'(if_valid), 32'd0);

        // Redirect coincident with acceptance; unaligned target.
        pcop = 1'b1; npc = 32'h0000_0203;
        tick();
        pcop = 1'b0;
        chk("kill_req", 32'(imem.imem_req), 32'd0);
        tick();
        chk("kill_addr", imem.imem_addr, 32'h0000_0200);
        chk("kill_valid", 32'(if_valid), 32'd0);

        // Redirect together with stall while holding a valid instruction.
        tick(); tick();
        chk("pre_flush_pc", if_pc, 32'h0000_0200);
        stall = 1'b1;
        tick();
        chk("pre_flush_valid", 32'(if_valid), 32'd1);
        pcop = 1'b1; npc = 32'hFFFF_FFFC;
        tick();
        pcop = 1'b0; stall = 1'b0;
        chk("stall_flush_valid", 32'(if_valid), 32'd0);
        chk("stall_flush_inst", if_inst, 32'h0000_0013);

        // Wrap of the fetch PC.
        for (int i = 0; i < 10 && !if_valid; i++) tick();
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pcplus4", if_pcplus4, 32'h0000_0000);
        chk("wrap_next_addr", imem.imem_addr, 32'h0000_0000);

        // Reset during WAIT; the late response must be ignored.
        lat_cfg = 2;
        tick();
        chk("wait_req", 32'(imem.imem_req), 32'd0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1; imem.imem_ready = 1'b0; stale_rvalid = 1'b1;
        tick(); tick();
        stale_rvalid = 1'b0;
        chk("stale_valid", 32'(if_valid), 32'd0);
        chk("stale_req", 32'(imem.imem_req), 32'd1);
        chk("stale_addr", imem.imem_addr, 32'h0000_0000);
        n_consumed = 0;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            stall           = ($urandom_range(0, 9) < 3);
            imem.imem_ready = ($urandom_range(0, 9) < 6);
            pcop            = ($urandom_range(0, 24) == 0);
            npc             = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'h0000_000F))
                                                          : $urandom;
            lat_cfg         = $urandom_range(0, 3);
            tick();
        end
        pcop = 1'b0; stall = 1'b0;
        chk("progress", 32'(n_consumed >= 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
